// File: rtl/soc_event_queue_pkg.sv
// Shared defaults and types for the SoC event queue.
// The top and its FIFO import this package.
package soc_event_queue_pkg;

  localparam int NB_EVENTS_DEF      = 160;
  localparam int EVENT_ID_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF     = 4;
  localparam int RR_PTR_WIDTH       = $clog2(NB_EVENTS_DEF);

  typedef logic [EVENT_ID_WIDTH_DEF-1:0] event_id_t;

endpackage

// File: rtl/soc_event_fifo.sv
// Register-based first-word-fall-through FIFO of event IDs.
// When empty, the head output shows the most recently popped entry.
module soc_event_fifo
  import soc_event_queue_pkg::*;
#(
  parameter int WIDTH = EVENT_ID_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i & ~empty_o;
  assign doPush  = push_i & (~full_o | doPop);

  // The slot just behind the read pointer still holds the last popped ID.
  assign head_o = empty_o ? mem_q[rdPtr_q - AW'(1)] : mem_q[rdPtr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/soc_event_queue.sv
// Latches SoC event pulses as pending bits and serialises them,
// round-robin, into a small FIFO of event IDs for the FC event port.
module soc_event_queue
  import soc_event_queue_pkg::*;
#(
  parameter int NB_EVENTS      = NB_EVENTS_DEF,
  parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_EVENTS-1:0]      events_i,
  output logic                      event_valid_o,
  input  logic                      event_ready_i,
  output logic [EVENT_ID_WIDTH-1:0] event_data_o,
  output logic                      overflow_o,
  output logic [EVENT_ID_WIDTH-1:0] overflow_id_o,
  output logic                      pending_o
);
  localparam int PTR_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;

  if (2**EVENT_ID_WIDTH < NB_EVENTS) begin : g_bad_id_width
    $error("EVENT_ID_WIDTH is too narrow to encode NB_EVENTS sources");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [NB_EVENTS-1:0]      pend_q;
  logic [NB_EVENTS-1:0]      pend_d;
  logic [NB_EVENTS-1:0]      grantMask;
  logic [NB_EVENTS-1:0]      lostMask;
  logic [PTR_W-1:0]          rrPtr_q;
  logic [PTR_W-1:0]          rrPtr_d;
  logic [PTR_W-1:0]          grantId;
  logic [PTR_W:0]            cand;
  logic                      grantFound;
  logic                      grant;
  logic                      pop;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic                      lostFound;
  logic                      overflow_q;
  logic                      overflow_d;
  logic [EVENT_ID_WIDTH-1:0] overflowId_q;
  logic [EVENT_ID_WIDTH-1:0] overflowId_d;

  // First pending source at or after the RR pointer, wrapping at NB_EVENTS.
  always_comb begin
    grantFound = 1'b0;
    grantId    = '0;
    cand       = '0;
    for (int i = 0; i < NB_EVENTS; i++) begin
      cand = (PTR_W+1)'(rrPtr_q) + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NB_EVENTS)) begin
        cand = cand - (PTR_W+1)'(NB_EVENTS);
      end
      if (!grantFound && pend_q[cand[PTR_W-1:0]]) begin
        grantFound = 1'b1;
        grantId    = cand[PTR_W-1:0];
      end
    end
  end

  // A fresh event on the source being granted re-arms it instead of being lost.
  always_comb begin
    pop          = event_valid_o & event_ready_i;
    grant        = grantFound & (~fifoFull | pop);
    grantMask    = grant ? (NB_EVENTS'(1) << grantId) : '0;
    lostMask     = events_i & pend_q & ~grantMask;
    pend_d       = (pend_q & ~grantMask) | events_i;
    rrPtr_d      = rrPtr_q;
    if (grant) begin
      rrPtr_d = (grantId == PTR_W'(NB_EVENTS - 1)) ? '0 : grantId + PTR_W'(1);
    end
    overflow_d   = |lostMask;
    overflowId_d = '0;
    lostFound    = 1'b0;
    for (int i = 0; i < NB_EVENTS; i++) begin
      if (lostMask[i] && !lostFound) begin
        lostFound    = 1'b1;
        overflowId_d = EVENT_ID_WIDTH'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q       <= '0;
      rrPtr_q      <= '0;
      overflow_q   <= 1'b0;
      overflowId_q <= '0;
    end else begin
      pend_q       <= pend_d;
      rrPtr_q      <= rrPtr_d;
      overflow_q   <= overflow_d;
      overflowId_q <= overflowId_d;
    end
  end

  soc_event_fifo #(
    .WIDTH (EVENT_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (grant),
    .pushData_i (EVENT_ID_WIDTH'(grantId)),
    .full_o     (fifoFull),
    .pop_i      (pop),
    .empty_o    (fifoEmpty),
    .head_o     (event_data_o)
  );

  assign event_valid_o = ~fifoEmpty;
  assign overflow_o    = overflow_q;
  assign overflow_id_o = overflowId_q;
  assign pending_o     = (|pend_q) | ~fifoEmpty;

endmodule

// File: tb/tb_soc_event_queue.sv
// Self-checking bench for soc_event_queue: directed table, hand sequences
// and randomized traffic, all compared against a queue-based reference model.
module tb_soc_event_queue;
  import soc_event_queue_pkg::*;

  localparam int NB    = 160;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NB-1:0] events_i;
  logic          event_ready_i;
  logic          event_valid_o;
  logic [W-1:0]  event_data_o;
  logic          overflow_o;
  logic [W-1:0]  overflow_id_o;
  logic          pending_o;

  soc_event_queue #(
    .NB_EVENTS      (NB),
    .EVENT_ID_WIDTH (W),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .events_i      (events_i),
    .event_valid_o (event_valid_o),
    .event_ready_i (event_ready_i),
    .event_data_o  (event_data_o),
    .overflow_o    (overflow_o),
    .overflow_id_o (overflow_id_o),
    .pending_o     (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a set of pending sources, a pointer and an ID queue.
  bit mPend [NB];
  int mPtr;
  int mQ [$];
  int mLast;
  bit mOvf;
  int mOvfId;

  int got [$];

  typedef struct {
    bit            doReset;
    logic [NB-1:0] ev;
    bit            rdy;
    bit            expValid;
    int            expData;
    bit            expOvf;
    bit            expPending;
  } vec_t;

  vec_t          vecs [10];
  logic [NB-1:0] rev;
  int            rid;
  int            nEv;
  bit            rrdy;
  int            nine;

  task automatic checkVal(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [NB-1:0] evMask(input int a, input int b = -1, input int c = -1);
    logic [NB-1:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  function automatic logic [NB-1:0] evRange(input int lo, input int hi);
    logic [NB-1:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NB; i++) mPend[i] = 1'b0;
    mPtr   = 0;
    mQ.delete();
    mLast  = 0;
    mOvf   = 1'b0;
    mOvfId = 0;
  endtask

  task automatic modelStep(input logic [NB-1:0] ev, input bit rdy);
    bit pop;
    int gnt;
    int lost;
    int idx;
    pop  = (mQ.size() > 0) && rdy;
    gnt  = -1;
    lost = -1;
    if (mQ.size() < DEPTH || pop) begin
      for (int k = 0; k < NB; k++) begin
        idx = (mPtr + k) % NB;
        if (mPend[idx]) begin
          gnt = idx;
          break;
        end
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (ev[i] && mPend[i] && i != gnt && lost < 0) lost = i;
    end
    if (pop) mLast = mQ.pop_front();
    if (gnt >= 0) begin
      mQ.push_back(gnt);
      mPend[gnt] = 1'b0;
      mPtr = (gnt + 1) % NB;
    end
    for (int i = 0; i < NB; i++) begin
      if (ev[i]) mPend[i] = 1'b1;
    end
    mOvf   = (lost >= 0);
    mOvfId = (lost >= 0) ? lost : 0;
  endtask

  task automatic checkOutput();
    bit anyPend;
    anyPend = 1'b0;
    for (int i = 0; i < NB; i++) anyPend |= mPend[i];
    checkVal("model valid", int'(event_valid_o), int'(mQ.size() > 0));
    checkVal("model data", int'(event_data_o), (mQ.size() > 0) ? mQ[0] : mLast);
    checkVal("model overflow", int'(overflow_o), int'(mOvf));
    if (mOvf) checkVal("model overflow id", int'(overflow_id_o), mOvfId);
    checkVal("model pending", int'(pending_o), int'(anyPend || mQ.size() > 0));
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 ns later.
  task automatic applyStimulus(input logic [NB-1:0] ev, input bit rdy);
    events_i      = ev;
    event_ready_i = rdy;
    @(posedge clk_i);
    modelStep(ev, rdy);
    #1;
    checkOutput();
  endtask

  task automatic resetDut();
    events_i      = '0;
    event_ready_i = 1'b0;
    rst_i         = 1'b1;
    @(posedge clk_i);
    #1;
    modelReset();
    rst_i = 1'b0;
  endtask

  // Ready held high; each head seen before a clock is consumed at that clock.
  task automatic drainCollect(input int cycles);
    got.delete();
    for (int k = 0; k < cycles; k++) begin
      if (event_valid_o) got.push_back(int'(event_data_o));
      applyStimulus('0, 1'b1);
    end
  endtask

  initial begin
    events_i      = '0;
    event_ready_i = 1'b0;
    rst_i         = 1'b1;
    modelReset();
    #2;
    checkVal("reset valid", int'(event_valid_o), 0);
    checkVal("reset data", int'(event_data_o), 0);
    checkVal("reset overflow", int'(overflow_o), 0);
    checkVal("reset overflow id", int'(overflow_id_o), 0);
    checkVal("reset pending", int'(pending_o), 0);
    resetDut();

    // Single pulse latency, then three-way round robin with pointer wrap.
    vecs[0] = '{1, evMask(5),          1, 0, -1,  0, 1};
    vecs[1] = '{0, '0,                 1, 1, 5,   0, 1};
    vecs[2] = '{0, '0,                 1, 0, -1,  0, 0};
    vecs[3] = '{1, evMask(3, 7, 150),  1, 0, -1,  0, 1};
    vecs[4] = '{0, '0,                 1, 1, 3,   0, 1};
    vecs[5] = '{0, '0,                 1, 1, 7,   0, 1};
    vecs[6] = '{0, '0,                 1, 1, 150, 0, 1};
    vecs[7] = '{0, evMask(3),          1, 0, -1,  0, 1};
    vecs[8] = '{0, '0,                 1, 1, 3,   0, 1};
    vecs[9] = '{0, '0,                 1, 0, -1,  0, 0};
    for (int r = 0; r < 10; r++) begin
      if (vecs[r].doReset) resetDut();
      applyStimulus(vecs[r].ev, vecs[r].rdy);
      checkVal($sformatf("row%0d valid", r), int'(event_valid_o), int'(vecs[r].expValid));
      if (vecs[r].expData >= 0)
        checkVal($sformatf("row%0d data", r), int'(event_data_o), vecs[r].expData);
      checkVal($sformatf("row%0d overflow", r), int'(overflow_o), int'(vecs[r].expOvf));
      checkVal($sformatf("row%0d pending", r), int'(pending_o), int'(vecs[r].expPending));
    end

    $display("[TB] back-pressure with IDs 0..5");
    resetDut();
    applyStimulus(evRange(0, 5), 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus('0, 1'b0);
      checkVal("stall data", int'(event_data_o), 0);
      checkVal("stall overflow", int'(overflow_o), 0);
    end
    checkVal("stall valid", int'(event_valid_o), 1);
    checkVal("stall pending", int'(pending_o), 1);
    drainCollect(12);
    checkVal("stall drain count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      checkVal($sformatf("stall drain order %0d", i), got[i], i);

    $display("[TB] overflow on double pulse of ID 9");
    resetDut();
    applyStimulus(evRange(0, 3), 1'b0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus((k == 10 || k == 12) ? evMask(9) : '0, 1'b0);
      if (k == 11) checkVal("overflow early", int'(overflow_o), 0);
      if (k == 12) begin
        checkVal("overflow pulse", int'(overflow_o), 1);
        checkVal("overflow id 9", int'(overflow_id_o), 9);
      end
    end
    applyStimulus('0, 1'b0);
    checkVal("overflow one-shot", int'(overflow_o), 0);
    drainCollect(12);
    checkVal("overflow drain count", got.size(), 5);
    nine = 0;
    foreach (got[i]) if (got[i] == 9) nine++;
    checkVal("overflow single 9", nine, 1);
    for (int i = 0; i < got.size() && i < 4; i++)
      checkVal($sformatf("overflow drain order %0d", i), got[i], i);

    $display("[TB] held event on ID 2");
    resetDut();
    got.delete();
    nine = 0;
    for (int k = 0; k < 10; k++) begin
      if (event_valid_o) got.push_back(int'(event_data_o));
      applyStimulus((k < 3) ? evMask(2) : '0, 1'b1);
      if (overflow_o) nine++;
    end
    checkVal("held count", got.size(), 3);
    foreach (got[i]) checkVal("held id", got[i], 2);
    checkVal("held overflow", nine, 0);

    $display("[TB] asynchronous reset with full queue");
    resetDut();
    applyStimulus(evRange(0, 7), 1'b0);
    for (int k = 0; k < 6; k++) applyStimulus('0, 1'b0);
    checkVal("pre-reset valid", int'(event_valid_o), 1);
    #3;
    rst_i = 1'b1;
    #1;
    checkVal("async valid", int'(event_valid_o), 0);
    checkVal("async data", int'(event_data_o), 0);
    checkVal("async overflow", int'(overflow_o), 0);
    checkVal("async overflow id", int'(overflow_id_o), 0);
    checkVal("async pending", int'(pending_o), 0);
    @(posedge clk_i);
    #1;
    modelReset();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus('0, 1'b1);
      checkVal("no stale valid", int'(event_valid_o), 0);
    end

    $display("[TB] randomized traffic");
    resetDut();
    for (int k = 0; k < 1500; k++) begin
      rev = '0;
      nEv = $urandom_range(0, 3);
      for (int j = 0; j < nEv; j++) begin
        rid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1))
                                          : int'($urandom_range(0, 11));
        rev[rid] = 1'b1;
      end
      rrdy = ((k / 60) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
      applyStimulus(rev, rrdy);
    end
    for (int k = 0; k < 200; k++) applyStimulus('0, 1'b1);
    checkVal("random final pending", int'(pending_o), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
